// File: rtl/nf_pwm_ramp.sv
`default_nettype none
// ============================================================================
// Module   : nf_pwm_ramp
// Purpose  : Duty-cycle ramp controller placed in front of nf_pwm. It moves
//            the PWM duty from its current value to a programmed target in
//            fixed steps at a programmed interval. Each new duty is written
//            to nf_pwm with a single-cycle strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   hclk      in   1    clock for all logic
//   hresetn   in   1    asynchronous active-low reset
//   addr      in   32   register address, bits [4:2] decoded
//   we        in   1    register write enable
//   wd        in   32   register write data
//   rd        out  32   register read data (combinational from addr)
//   pwm_addr  out  32   nf_pwm duty register address (constant)
//   pwm_we    out  1    one-cycle duty write strobe to nf_pwm
//   pwm_wd    out  32   duty to nf_pwm, zero-extended
//   done      out  1    ramp reached target; cleared by the next start
// Register map (word offsets)
//   0x00 CTRL {run}  0x04 TARGET  0x08 STEP  0x0C INTERVAL
//   0x10 CUR (RO)    0x14 STATUS (RO) {busy, done}
// ============================================================================
module nf_pwm_ramp #(
    parameter int          PWM_WIDTH     = 8,
    parameter int          INT_WIDTH     = 16,
    parameter logic [31:0] PWM_DUTY_ADDR = 32'h0000_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [31:0] pwm_addr,
    output logic        pwm_we,
    output logic [31:0] pwm_wd,
    output logic        done
);

    localparam logic [2:0] c_reg_ctrl     = 3'd0;
    localparam logic [2:0] c_reg_target   = 3'd1;
    localparam logic [2:0] c_reg_step     = 3'd2;
    localparam logic [2:0] c_reg_interval = 3'd3;
    localparam logic [2:0] c_reg_cur      = 3'd4;
    localparam logic [2:0] c_reg_status   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PWM_WIDTH-1:0]   r_target;
    logic [PWM_WIDTH-1:0]   r_step;
    logic [PWM_WIDTH-1:0]   r_cur;
    logic [INT_WIDTH-1:0]   r_interval;
    logic [INT_WIDTH-1:0]   r_cnt;
    logic                   r_run;
    logic                   r_done;

    logic [2:0]             w_reg_sel;
    logic                   w_ctrl_wr;
    logic                   w_start;
    logic                   w_stop;
    logic                   w_launch;
    logic                   w_enter_done;
    logic                   w_load_cnt;
    logic                   w_busy;
    logic [PWM_WIDTH-1:0]   w_step_eff;
    logic [PWM_WIDTH-1:0]   w_gap;
    logic [PWM_WIDTH-1:0]   w_new_cur;
    logic                   w_unused;

    assign w_reg_sel = addr[4:2];
    assign w_ctrl_wr = we && (w_reg_sel == c_reg_ctrl);
    assign w_start   = w_ctrl_wr && wd[0];
    assign w_stop    = w_ctrl_wr && !wd[0];
    // Only a start from a parked state begins a new ramp; run=1 while busy is a no-op.
    assign w_launch  = w_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_busy    = (r_state == ST_WAIT) || (r_state == ST_STEP);
    // Upper address bits and unused write-data bits are intentionally ignored.
    assign w_unused  = ^{addr, wd};

    // Next duty value: move toward the target, clamping on the target so the
    // gap comparison (done before any add/subtract) rules out overshoot and wrap.
    always_comb begin
        w_step_eff = (r_step == '0) ? {{(PWM_WIDTH-1){1'b0}}, 1'b1} : r_step;
        w_gap      = '0;
        w_new_cur  = r_cur;
        if (r_cur < r_target) begin
            w_gap     = r_target - r_cur;
            w_new_cur = (w_gap <= w_step_eff) ? r_target : (r_cur + w_step_eff);
        end else if (r_cur > r_target) begin
            w_gap     = r_cur - r_target;
            w_new_cur = (w_gap <= w_step_eff) ? r_target : (r_cur - w_step_eff);
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_stop)              w_state_next = ST_IDLE;
                else if (r_cnt == '0)    w_state_next = ST_STEP;
            end
            ST_STEP: begin
                // The step itself always completes; a stop only redirects the exit.
                if (w_stop)                      w_state_next = ST_IDLE;
                else if (w_new_cur == r_target)  w_state_next = ST_DONE;
                else                             w_state_next = ST_WAIT;
            end
            ST_DONE: begin
                if (w_start)      w_state_next = ST_WAIT;
                else if (w_stop)  w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_enter_done = (r_state == ST_STEP) && (w_state_next == ST_DONE);
    assign w_load_cnt   = (w_state_next == ST_WAIT) && (r_state != ST_WAIT);

    // ------------------------------------------------------------------
    // Registers and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_target   <= '0;
            r_step     <= '0;
            r_interval <= '0;
            r_cur      <= '0;
            r_cnt      <= '0;
            r_run      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (we && (w_reg_sel == c_reg_target))   r_target   <= wd[PWM_WIDTH-1:0];
            if (we && (w_reg_sel == c_reg_step))     r_step     <= wd[PWM_WIDTH-1:0];
            if (we && (w_reg_sel == c_reg_interval)) r_interval <= wd[INT_WIDTH-1:0];

            // Reaching the target clears run so software sees the ramp as finished.
            if (w_enter_done)     r_run <= 1'b0;
            else if (w_ctrl_wr)   r_run <= wd[0];

            if (w_launch)          r_done <= 1'b0;
            else if (w_enter_done) r_done <= 1'b1;

            if (w_load_cnt)
                r_cnt <= r_interval;
            else if ((r_state == ST_WAIT) && (r_cnt != '0))
                r_cnt <= r_cnt - 1'b1;

            if (r_state == ST_STEP) r_cur <= w_new_cur;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pwm_addr = PWM_DUTY_ADDR;
    assign pwm_we   = (r_state == ST_STEP);
    assign done     = r_done;

    // During STEP the strobe carries the freshly computed duty; otherwise the
    // held duty is shown so the bus never sees a stale intermediate value.
    always_comb begin
        pwm_wd = '0;
        pwm_wd[PWM_WIDTH-1:0] = (r_state == ST_STEP) ? w_new_cur : r_cur;
    end

    always_comb begin
        rd = '0;
        case (w_reg_sel)
            c_reg_ctrl:     rd[0]               = r_run;
            c_reg_target:   rd[PWM_WIDTH-1:0]   = r_target;
            c_reg_step:     rd[PWM_WIDTH-1:0]   = r_step;
            c_reg_interval: rd[INT_WIDTH-1:0]   = r_interval;
            c_reg_cur:      rd[PWM_WIDTH-1:0]   = r_cur;
            c_reg_status:   rd[1:0]             = {w_busy, r_done};
            default:        rd                  = '0;
        endcase
    end

endmodule
`default_nettype wire
